mult_error_monitor: RTL and testbench

Synthesizable, self-running error-characterisation engine for approximate multipliers such as MITCHEL. It generates operand pairs in random (LFSR) or exhaustive mode, drives them into an external approximate multiplier, and compares each returned product with an internally computed exact product. It accumulates error statistics in hardware, from which software derives MED, NMED, mean bias and error rate. It replaces the software-only characterisation flow and runs on FPGA at full clock rate.

---
 rtl/mult_error_monitor.sv | 324 ++++++++++++++++++++++++++++++++
 tb/tb_mult_error_monitor.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_error_monitor.sv
// mult_error_monitor
// Self-running error-characterisation engine for approximate multipliers.
// Generates operand pairs (LFSR random or exhaustive sweep), drives them to an
// external multiplier, realigns the exact product with the returned product
// and accumulates error statistics (count, sum, signed sum, maximum).
module mult_error_monitor #(
    parameter int          W         = 8,
    parameter logic [31:0] N_SAMPLES = 32'd1000,
    parameter int          DUT_LAT   = 0,
    parameter logic [31:0] SEED      = 32'hACE1_2468
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    output logic [W-1:0]      op_x,
    output logic [W-1:0]      op_y,
    output logic              op_valid,
    input  logic [2*W:0]      dut_p,
    output logic              busy,
    output logic              done,
    output logic [31:0]       n_samples,
    output logic [31:0]       zero_cnt,
    output logic [31:0]       err_cnt,
    output logic [2*W+32:0]   sum_ed,
    output logic signed [2*W+33:0] sum_err,
    output logic [2*W:0]      max_ed
);

    localparam int          PW        = 2 * W + 1;
    localparam int          ED_W      = PW + 32;
    localparam int          ER_W      = PW + 33;
    localparam logic [31:0] EXH_LAST  = 32'((64'd1 << (2 * W)) - 64'd1);
    localparam logic [31:0] RND_LAST  = N_SAMPLES - 32'd1;
    // Right-shift Galois mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0] LFSR_MASK = 32'h8020_0003;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One Galois step: shift right, fold the tap mask in when a 1 falls out.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) begin
            r = r ^ LFSR_MASK;
        end else begin
            r = r;
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Control / operand generation state
    // ------------------------------------------------------------------
    state_t         state_q, state_d;
    logic           mode_q, mode_d;
    logic [31:0]    lfsr_q, lfsr_d;
    logic [31:0]    idx_q, idx_d;
    logic [W-1:0]   op_x_q, op_x_d;
    logic [W-1:0]   op_y_q, op_y_d;
    logic           op_valid_q, op_valid_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;

    logic           start_ok_s;
    logic           last_issue_s;
    logic [31:0]    lfsr_next_s;
    logic [31:0]    idx_next_s;

    // Exact product of the pair currently on the operand outputs
    logic [2*W-1:0] prod_s;
    logic [PW-1:0]  exact_s;

    // Exact product / tags aligned with the dut_p currently on the input
    logic [PW-1:0]  cmp_exact_s;
    logic           cmp_vld_s;
    logic           cmp_last_s;

    assign start_ok_s   = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign last_issue_s = op_valid_q && (idx_q == (mode_q ? EXH_LAST : RND_LAST));
    assign lfsr_next_s  = lfsr_step(lfsr_q);
    assign idx_next_s   = idx_q + 32'd1;
    assign prod_s       = {{W{1'b0}}, op_x_q} * {{W{1'b0}}, op_y_q};
    assign exact_s      = {1'b0, prod_s};

    // Next-state, operand sequencing and registered status outputs
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        lfsr_d     = lfsr_q;
        idx_d      = idx_q;
        op_x_d     = op_x_q;
        op_y_d     = op_y_q;
        op_valid_d = op_valid_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_ok_s) begin
                    state_d    = S_RUN;
                    mode_d     = mode;
                    idx_d      = 32'd0;
                    lfsr_d     = SEED;
                    op_valid_d = 1'b1;
                    if (mode) begin
                        op_x_d = {W{1'b0}};
                        op_y_d = {W{1'b0}};
                    end else begin
                        op_x_d = SEED[W-1:0];
                        op_y_d = SEED[2*W-1:W];
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_RUN: begin
                if (last_issue_s) begin
                    // Operands hold their final values once the run is issued
                    op_valid_d = 1'b0;
                end else begin
                    idx_d  = idx_next_s;
                    lfsr_d = lfsr_next_s;
                    if (mode_q) begin
                        op_x_d = idx_next_s[2*W-1:W];
                        op_y_d = idx_next_s[W-1:0];
                    end else begin
                        op_x_d = lfsr_next_s[W-1:0];
                        op_y_d = lfsr_next_s[2*W-1:W];
                    end
                end
                if (cmp_vld_s && cmp_last_s) begin
                    state_d = S_DONE;
                end else if (last_issue_s) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_RUN;
                end
            end
            S_DRAIN: begin
                if (cmp_vld_s && cmp_last_s) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d    = S_IDLE;
                op_valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d == S_RUN) || (state_d == S_DRAIN);
        done_d = (state_d == S_DONE);
    end

    // Control registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            mode_q     <= 1'b0;
            lfsr_q     <= 32'd0;
            idx_q      <= 32'd0;
            op_x_q     <= {W{1'b0}};
            op_y_q     <= {W{1'b0}};
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            lfsr_q     <= lfsr_d;
            idx_q      <= idx_d;
            op_x_q     <= op_x_d;
            op_y_q     <= op_y_d;
            op_valid_q <= op_valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // ------------------------------------------------------------------
    // Exact-product delay line: the current pair's product is the first
    // stage, followed by DUT_LAT registered stages matching the multiplier.
    // ------------------------------------------------------------------
    generate
        if (DUT_LAT == 0) begin : g_comb_dut
            assign cmp_exact_s = exact_s;
            assign cmp_vld_s   = op_valid_q;
            assign cmp_last_s  = last_issue_s;
        end else begin : g_pipe_dut
            logic [PW-1:0]      dl_exact_q [DUT_LAT];
            logic [PW-1:0]      dl_exact_d [DUT_LAT];
            logic [DUT_LAT-1:0] dl_vld_q, dl_vld_d;
            logic [DUT_LAT-1:0] dl_last_q, dl_last_d;

            // Shift the product and its valid/last tags one stage per cycle
            always_comb begin
                dl_vld_d      = dl_vld_q;
                dl_last_d     = dl_last_q;
                dl_exact_d[0] = exact_s;
                dl_vld_d[0]   = op_valid_q;
                dl_last_d[0]  = last_issue_s;
                for (int i = 1; i < DUT_LAT; i++) begin
                    dl_exact_d[i] = dl_exact_q[i-1];
                    dl_vld_d[i]   = dl_vld_q[i-1];
                    dl_last_d[i]  = dl_last_q[i-1];
                end
            end

            // Delay-line registers; reset flushes any in-flight pairs
            always_ff @(posedge clk) begin
                if (rst) begin
                    dl_vld_q  <= {DUT_LAT{1'b0}};
                    dl_last_q <= {DUT_LAT{1'b0}};
                    for (int i = 0; i < DUT_LAT; i++) begin
                        dl_exact_q[i] <= {PW{1'b0}};
                    end
                end else begin
                    dl_vld_q  <= dl_vld_d;
                    dl_last_q <= dl_last_d;
                    for (int i = 0; i < DUT_LAT; i++) begin
                        dl_exact_q[i] <= dl_exact_d[i];
                    end
                end
            end

            assign cmp_exact_s = dl_exact_q[DUT_LAT-1];
            assign cmp_vld_s   = dl_vld_q[DUT_LAT-1];
            assign cmp_last_s  = dl_last_q[DUT_LAT-1];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Error statistics
    // ------------------------------------------------------------------
    logic [31:0]   n_samples_q, n_samples_d;
    logic [31:0]   zero_cnt_q, zero_cnt_d;
    logic [31:0]   err_cnt_q, err_cnt_d;
    logic [ED_W-1:0] sum_ed_q, sum_ed_d;
    logic [ER_W-1:0] sum_err_q, sum_err_d;
    logic [PW-1:0] max_ed_q, max_ed_d;

    logic [PW:0]   diff_s;
    logic [PW:0]   neg_diff_s;
    logic [PW-1:0] ed_s;

    // Signed difference is one bit wider than the product so it never wraps
    assign diff_s     = {1'b0, dut_p} - {1'b0, cmp_exact_s};
    assign neg_diff_s = {(PW+1){1'b0}} - diff_s;
    assign ed_s       = diff_s[PW] ? neg_diff_s[PW-1:0] : diff_s[PW-1:0];

    // Clear on an accepted start, otherwise fold in each aligned sample
    always_comb begin
        n_samples_d = n_samples_q;
        zero_cnt_d  = zero_cnt_q;
        err_cnt_d   = err_cnt_q;
        sum_ed_d    = sum_ed_q;
        sum_err_d   = sum_err_q;
        max_ed_d    = max_ed_q;
        if (start_ok_s) begin
            n_samples_d = 32'd0;
            zero_cnt_d  = 32'd0;
            err_cnt_d   = 32'd0;
            sum_ed_d    = {ED_W{1'b0}};
            sum_err_d   = {ER_W{1'b0}};
            max_ed_d    = {PW{1'b0}};
        end else if (cmp_vld_s) begin
            n_samples_d = n_samples_q + 32'd1;
            sum_ed_d    = sum_ed_q + {32'd0, ed_s};
            sum_err_d   = sum_err_q + {{32{diff_s[PW]}}, diff_s};
            if (cmp_exact_s == {PW{1'b0}}) begin
                zero_cnt_d = zero_cnt_q + 32'd1;
            end else begin
                zero_cnt_d = zero_cnt_q;
            end
            if (ed_s != {PW{1'b0}}) begin
                err_cnt_d = err_cnt_q + 32'd1;
            end else begin
                err_cnt_d = err_cnt_q;
            end
            if (ed_s > max_ed_q) begin
                max_ed_d = ed_s;
            end else begin
                max_ed_d = max_ed_q;
            end
        end else begin
            n_samples_d = n_samples_q;
        end
    end

    // Statistics registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            n_samples_q <= 32'd0;
            zero_cnt_q  <= 32'd0;
            err_cnt_q   <= 32'd0;
            sum_ed_q    <= {ED_W{1'b0}};
            sum_err_q   <= {ER_W{1'b0}};
            max_ed_q    <= {PW{1'b0}};
        end else begin
            n_samples_q <= n_samples_d;
            zero_cnt_q  <= zero_cnt_d;
            err_cnt_q   <= err_cnt_d;
            sum_ed_q    <= sum_ed_d;
            sum_err_q   <= sum_err_d;
            max_ed_q    <= max_ed_d;
        end
    end

    assign op_x      = op_x_q;
    assign op_y      = op_y_q;
    assign op_valid  = op_valid_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign n_samples = n_samples_q;
    assign zero_cnt  = zero_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign sum_ed    = sum_ed_q;
    assign sum_err   = sum_err_q;
    assign max_ed    = max_ed_q;

endmodule

// File: tb/tb_mult_error_monitor.sv
// Directed testbench for mult_error_monitor: three instances cover random
// mode at W=8, exhaustive mode at W=2 and a 3-stage pipelined DUT at W=4.
module tb_mult_error_monitor;

    logic clk;
    logic rst;
    logic bias_a;
    int   n_checks;
    int   n_errors;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- instance A: W=8, random, combinational DUT ----------
    logic        start_a, mode_a, opv_a, busy_a, done_a;
    logic [7:0]  opx_a, opy_a;
    logic [16:0] dutp_a, max_a;
    logic [31:0] ns_a, zc_a, ec_a;
    logic [48:0] sed_a;
    logic signed [49:0] serr_a;

    assign dutp_a = {9'd0, opx_a} * {9'd0, opy_a} + {16'd0, bias_a};

    mult_error_monitor #(.W(8), .N_SAMPLES(32'd1000), .DUT_LAT(0), .SEED(32'hACE1_2468)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
        .op_x(opx_a), .op_y(opy_a), .op_valid(opv_a), .dut_p(dutp_a),
        .busy(busy_a), .done(done_a), .n_samples(ns_a), .zero_cnt(zc_a),
        .err_cnt(ec_a), .sum_ed(sed_a), .sum_err(serr_a), .max_ed(max_a)
    );

    // ---------------- instance B: W=2, DUT returns 0 ----------------------
    logic        start_b, mode_b, opv_b, busy_b, done_b;
    logic [1:0]  opx_b, opy_b;
    logic [4:0]  dutp_b, max_b;
    logic [31:0] ns_b, zc_b, ec_b;
    logic [36:0] sed_b;
    logic signed [37:0] serr_b;

    assign dutp_b = 5'd0;

    mult_error_monitor #(.W(2), .N_SAMPLES(32'd5), .DUT_LAT(0), .SEED(32'hACE1_2468)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
        .op_x(opx_b), .op_y(opy_b), .op_valid(opv_b), .dut_p(dutp_b),
        .busy(busy_b), .done(done_b), .n_samples(ns_b), .zero_cnt(zc_b),
        .err_cnt(ec_b), .sum_ed(sed_b), .sum_err(serr_b), .max_ed(max_b)
    );

    // ---------------- instance C: W=4, exact 3-stage pipelined DUT --------
    logic        start_c, mode_c, opv_c, busy_c, done_c;
    logic [3:0]  opx_c, opy_c;
    logic [8:0]  dutp_c, max_c, p1_c, p2_c, p3_c;
    logic [31:0] ns_c, zc_c, ec_c;
    logic [40:0] sed_c;
    logic signed [41:0] serr_c;

    always_ff @(posedge clk) begin
        p1_c <= {5'd0, opx_c} * {5'd0, opy_c};
        p2_c <= p1_c;
        p3_c <= p2_c;
    end
    assign dutp_c = p3_c;

    mult_error_monitor #(.W(4), .N_SAMPLES(32'd1000), .DUT_LAT(3), .SEED(32'hACE1_2468)) u_c (
        .clk(clk), .rst(rst), .start(start_c), .mode(mode_c),
        .op_x(opx_c), .op_y(opy_c), .op_valid(opv_c), .dut_p(dutp_c),
        .busy(busy_c), .done(done_c), .n_samples(ns_c), .zero_cnt(zc_c),
        .err_cnt(ec_c), .sum_ed(sed_c), .sum_err(serr_c), .max_ed(max_c)
    );

    // ---------------- helpers --------------------------------------------
    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_step(input logic [31:0] s);
        logic [31:0] r;
        r = s >> 1;
        if (s[0]) r = r ^ 32'h8020_0003;
        return r;
    endfunction

    function automatic logic sel_busy(input int sel);
        case (sel)
            0: return busy_a;
            1: return busy_b;
            default: return busy_c;
        endcase
    endfunction

    function automatic logic sel_valid(input int sel);
        case (sel)
            0: return opv_a;
            1: return opv_b;
            default: return opv_c;
        endcase
    endfunction

    // Pulse start on one instance; returns #1 after the start edge
    task automatic pulse_start(input int sel, input logic m);
        case (sel)
            0: begin mode_a = m; start_a = 1'b1; end
            1: begin mode_b = m; start_b = 1'b1; end
            default: begin mode_c = m; start_c = 1'b1; end
        endcase
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0; mode_c = 1'b0;
    endtask

    // Count busy and op_valid cycles until busy drops (bounded); optionally
    // pulses start on instance A mid-run at cycle poke_at.
    task automatic run_wait(input int sel, input int limit, input int poke_at,
                            output int busy_n, output int valid_n);
        busy_n = 0;
        valid_n = 0;
        while (sel_busy(sel) && busy_n < limit) begin
            if (sel_valid(sel)) valid_n++;
            @(posedge clk); #1;
            busy_n++;
            if (sel == 0 && busy_n == poke_at) begin
                start_a = 1'b1;
            end else if (sel == 0 && poke_at > 0 && busy_n == poke_at + 1) begin
                start_a = 1'b0;
                check_eq("midrun_start_ignored", 64'(ns_a), 64'(poke_at + 1));
            end
        end
        if (sel_busy(sel)) check_eq("run_timeout", 64'd1, 64'd0);
    endtask

    // ---------------- stimulus -------------------------------------------
    initial begin
        int bn, vn, zref;
        logic [31:0] s;
        logic saw_done;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1; bias_a = 1'b0;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        mode_a = 1'b0; mode_b = 1'b0; mode_c = 1'b0;

        // Reference zero count over the first 1000 random pairs
        s = 32'hACE1_2468;
        zref = 0;
        for (int i = 0; i < 1000; i++) begin
            if (s[7:0] == 8'd0 || s[15:8] == 8'd0) zref++;
            s = ref_step(s);
        end

        // Reset held 3 cycles with start toggling
        for (int i = 0; i < 3; i++) begin
            start_a = (i % 2 == 0);
            @(posedge clk); #1;
        end
        check_eq("rst_opx", 64'(opx_a), 64'd0);
        check_eq("rst_opy", 64'(opy_a), 64'd0);
        check_eq("rst_opvalid", 64'(opv_a), 64'd0);
        check_eq("rst_busy", 64'(busy_a), 64'd0);
        check_eq("rst_done", 64'(done_a), 64'd0);
        check_eq("rst_nsamp", 64'(ns_a), 64'd0);
        check_eq("rst_zero", 64'(zc_a), 64'd0);
        check_eq("rst_err", 64'(ec_a), 64'd0);
        check_eq("rst_sum_ed", 64'(sed_a), 64'd0);
        check_eq("rst_sum_err", 64'(serr_a), 64'd0);
        check_eq("rst_max", 64'(max_a), 64'd0);
        rst = 1'b0; start_a = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("idle_busy", 64'(busy_a), 64'd0);
        check_eq("idle_opvalid", 64'(opv_a), 64'd0);
        check_eq("idle_done", 64'(done_a), 64'd0);

        // Exact loopback, random mode, with a start pulse ignored mid-run
        pulse_start(0, 1'b0);
        check_eq("a_pair0_x", 64'(opx_a), 64'h68);
        check_eq("a_pair0_y", 64'(opy_a), 64'h24);
        check_eq("a_pair0_valid", 64'(opv_a), 64'd1);
        check_eq("a_busy_start", 64'(busy_a), 64'd1);
        run_wait(0, 3000, 100, bn, vn);
        check_eq("a_busy_cycles", 64'(bn), 64'd1000);
        check_eq("a_valid_cycles", 64'(vn), 64'd1000);
        check_eq("a_done", 64'(done_a), 64'd1);
        check_eq("a_nsamp", 64'(ns_a), 64'd1000);
        check_eq("a_err", 64'(ec_a), 64'd0);
        check_eq("a_sum_ed", 64'(sed_a), 64'd0);
        check_eq("a_sum_err", 64'(serr_a), 64'd0);
        check_eq("a_max", 64'(max_a), 64'd0);
        check_eq("a_zero", 64'(zc_a), 64'(zref));
        @(posedge clk); #1;
        check_eq("a_done_hold", 64'(ns_a), 64'd1000);

        // Biased DUT (+1), restarted from DONE
        bias_a = 1'b1;
        pulse_start(0, 1'b0);
        check_eq("b1_done_drop", 64'(done_a), 64'd0);
        check_eq("b1_clear", 64'(ns_a), 64'd0);
        run_wait(0, 3000, -1, bn, vn);
        check_eq("b1_busy_cycles", 64'(bn), 64'd1000);
        check_eq("b1_err", 64'(ec_a), 64'd1000);
        check_eq("b1_sum_ed", 64'(sed_a), 64'd1000);
        check_eq("b1_sum_err", 64'($signed(serr_a)), 64'd1000);
        check_eq("b1_max", 64'(max_a), 64'd1);
        check_eq("b1_zero", 64'(zc_a), 64'(zref));

        // Reset at cycle 500 of a run
        bias_a = 1'b0;
        pulse_start(0, 1'b0);
        repeat (500) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_eq("abort_busy", 64'(busy_a), 64'd0);
        check_eq("abort_valid", 64'(opv_a), 64'd0);
        check_eq("abort_opx", 64'(opx_a), 64'd0);
        check_eq("abort_nsamp", 64'(ns_a), 64'd0);
        check_eq("abort_sum_ed", 64'(sed_a), 64'd0);
        rst = 1'b0;
        saw_done = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            saw_done = saw_done | done_a;
        end
        check_eq("abort_no_done", 64'(saw_done), 64'd0);
        check_eq("abort_stay_idle", 64'(busy_a), 64'd0);

        // W=2: random run, then restart from DONE in exhaustive mode
        pulse_start(1, 1'b0);
        run_wait(1, 100, -1, bn, vn);
        check_eq("w2_rnd_nsamp", 64'(ns_b), 64'd5);
        check_eq("w2_rnd_done", 64'(done_b), 64'd1);
        pulse_start(1, 1'b1);
        check_eq("w2_restart_clear", 64'(ns_b), 64'd0);
        check_eq("w2_restart_done", 64'(done_b), 64'd0);
        check_eq("w2_restart_x", 64'(opx_b), 64'd0);
        check_eq("w2_restart_y", 64'(opy_b), 64'd0);
        run_wait(1, 100, -1, bn, vn);
        check_eq("w2_busy_cycles", 64'(bn), 64'd16);
        check_eq("w2_valid_cycles", 64'(vn), 64'd16);
        check_eq("w2_nsamp", 64'(ns_b), 64'd16);
        check_eq("w2_zero", 64'(zc_b), 64'd7);
        check_eq("w2_err", 64'(ec_b), 64'd9);
        check_eq("w2_sum_ed", 64'(sed_b), 64'd36);
        check_eq("w2_sum_err", 64'($signed(serr_b)), -64'sd36);
        check_eq("w2_max", 64'(max_b), 64'd9);

        // W=4 exhaustive with 3-stage pipelined exact multiplier
        pulse_start(2, 1'b1);
        run_wait(2, 1000, -1, bn, vn);
        check_eq("pipe_busy_cycles", 64'(bn), 64'd259);
        check_eq("pipe_valid_cycles", 64'(vn), 64'd256);
        check_eq("pipe_done", 64'(done_c), 64'd1);
        check_eq("pipe_nsamp", 64'(ns_c), 64'd256);
        check_eq("pipe_zero", 64'(zc_c), 64'd31);
        check_eq("pipe_err", 64'(ec_c), 64'd0);
        check_eq("pipe_sum_ed", 64'(sed_c), 64'd0);
        check_eq("pipe_sum_err", 64'(serr_c), 64'd0);
        check_eq("pipe_max", 64'(max_c), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
